// File: rtl/mil_transmitter.sv
// MIL-STD-1553B word transmitter: sync + Manchester II data + odd parity, one-word holding buffer.
// Optional build macro MIL_TX_PARITY_INJECT_EN adds iPARITY_INV for parity fault injection.
module mil_transmitter #(
  parameter int CLK_PER_HALF_BIT = 8
) (
  input  logic        iCLK,
  input  logic        iRESET_N,
  input  logic [15:0] iDATA,
  input  logic        iCD,
  input  logic        iWR,
`ifdef MIL_TX_PARITY_INJECT_EN
  input  logic        iPARITY_INV,
`endif
  output logic        oREADY,
  output logic [1:0]  oDO,
  output logic        oBUSY,
  output logic        oDONE
);

  localparam logic [7:0] HB_LAST       = 8'(CLK_PER_HALF_BIT - 1);
  localparam logic [5:0] LAST_HALF_BIT = 6'd39;

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state, state_n;
  logic        hold_full, hold_cd, hold_pinv;
  logic [15:0] hold_data;
  logic        wr_accept, take;
  logic [39:0] frame;
  logic [39:0] shift_q, shift_n;
  logic [7:0]  hb_cnt, hb_cnt_n;
  logic [5:0]  bit_cnt, bit_cnt_n;
  logic [1:0]  do_n;
  logic        busy_n, done_n;

  function automatic logic [1:0] encode(input logic hb);
    return hb ? 2'b10 : 2'b01;
  endfunction

  // Whole 40-half-bit frame, first half-bit in bit 39.
  function automatic logic [39:0] build_frame(input logic [15:0] d, input logic cd, input logic pinv);
    logic [39:0] f;
    logic        p;
    p        = (~^d) ^ pinv;
    f[39:34] = cd ? 6'b111000 : 6'b000111;
    for (int i = 0; i < 16; i++) begin
      f[33 - 2*i] = d[15 - i];
      f[32 - 2*i] = ~d[15 - i];
    end
    f[1] = p;
    f[0] = ~p;
    return f;
  endfunction

  assign wr_accept = iWR && !hold_full;
  assign oREADY    = ~hold_full;
  assign frame     = build_frame(hold_data, hold_cd, hold_pinv);

  always_ff @(posedge iCLK or negedge iRESET_N) begin
    if (!iRESET_N) begin
      hold_full <= 1'b0;
      hold_data <= '0;
      hold_cd   <= 1'b0;
    end else if (take) begin
      hold_full <= 1'b0;
    end else if (wr_accept) begin
      hold_full <= 1'b1;
      hold_data <= iDATA;
      hold_cd   <= iCD;
    end
  end

`ifdef MIL_TX_PARITY_INJECT_EN
  always_ff @(posedge iCLK or negedge iRESET_N) begin
    if (!iRESET_N)
      hold_pinv <= 1'b0;
    else if (wr_accept)
      hold_pinv <= iPARITY_INV;
  end
`else
  assign hold_pinv = 1'b0;
`endif

  always_ff @(posedge iCLK or negedge iRESET_N) begin
    if (!iRESET_N) begin
      state   <= IDLE;
      shift_q <= '0;
      hb_cnt  <= '0;
      bit_cnt <= '0;
      oDO     <= 2'b00;
      oBUSY   <= 1'b0;
      oDONE   <= 1'b0;
    end else begin
      state   <= state_n;
      shift_q <= shift_n;
      hb_cnt  <= hb_cnt_n;
      bit_cnt <= bit_cnt_n;
      oDO     <= do_n;
      oBUSY   <= busy_n;
      oDONE   <= done_n;
    end
  end

  // shift_q holds the half-bits still to be shown; oDO carries the current one.
  always_comb begin
    state_n   = state;
    shift_n   = shift_q;
    hb_cnt_n  = hb_cnt;
    bit_cnt_n = bit_cnt;
    do_n      = oDO;
    busy_n    = oBUSY;
    done_n    = 1'b0;
    take      = 1'b0;
    if (state == IDLE) begin
      do_n   = 2'b00;
      busy_n = 1'b0;
      if (hold_full) begin
        take      = 1'b1;
        state_n   = SEND;
        shift_n   = {frame[38:0], 1'b0};
        hb_cnt_n  = '0;
        bit_cnt_n = '0;
        do_n      = encode(frame[39]);
        busy_n    = 1'b1;
      end
    end else begin
      if (hb_cnt == HB_LAST) begin
        hb_cnt_n = '0;
        if (bit_cnt == LAST_HALF_BIT) begin
          done_n = 1'b1;
          if (hold_full) begin
            take      = 1'b1;
            shift_n   = {frame[38:0], 1'b0};
            bit_cnt_n = '0;
            do_n      = encode(frame[39]);
          end else begin
            state_n   = IDLE;
            shift_n   = '0;
            bit_cnt_n = '0;
            do_n      = 2'b00;
            busy_n    = 1'b0;
          end
        end else begin
          bit_cnt_n = bit_cnt + 6'd1;
          shift_n   = {shift_q[38:0], 1'b0};
          do_n      = encode(shift_q[39]);
        end
      end else begin
        hb_cnt_n = hb_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mil_transmitter.sv
// Self-checking bench for mil_transmitter: vector table, random words, chaining, write-while-full, reset mid-word.
// Build with MIL_TX_PARITY_INJECT_EN to also exercise parity injection.
module tb_mil_transmitter;

  localparam int HB       = 8;
  localparam int WORD_CYC = 40 * HB;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data  = '0;
  logic        cd    = 1'b0;
  logic        wr    = 1'b0;
`ifdef MIL_TX_PARITY_INJECT_EN
  logic        parity_inv = 1'b0;
`endif
  logic        ready;
  logic [1:0]  dout;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  logic [1:0] do_log   [0:1023];
  logic       busy_log [0:1023];
  logic       done_log [0:1023];

  typedef struct {
    logic [15:0] data;
    logic        cd;
    logic        pinv;
    logic        exp_p;
  } vec_t;

  vec_t vecs[$];

  mil_transmitter #(.CLK_PER_HALF_BIT(HB)) dut (
    .iCLK        (clk),
    .iRESET_N    (rst_n),
    .iDATA       (data),
    .iCD         (cd),
    .iWR         (wr),
`ifdef MIL_TX_PARITY_INJECT_EN
    .iPARITY_INV (parity_inv),
`endif
    .oREADY      (ready),
    .oDO         (dout),
    .oBUSY       (busy),
    .oDONE       (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Waits (bounded) for an empty holding buffer, then strobes one write.
  task automatic writeWord(input logic [15:0] d, input logic c, input logic p);
    int waited = 0;
    @(negedge clk);
    while (!ready && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (!ready) checkOutput("ready timeout", 32'(ready), 32'd1);
    data = d;
    cd   = c;
`ifdef MIL_TX_PARITY_INJECT_EN
    parity_inv = p;
`else
    if (p) $display("[TB] note: parity inject requested but not built in");
`endif
    wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic record(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      do_log[i]   = dout;
      busy_log[i] = busy;
      done_log[i] = done;
    end
  endtask

  // Expected half-bit sequence straight from the word-format rules.
  function automatic logic [39:0] modelHalfBits(input logic [15:0] d, input logic c, input logic p);
    bit          q[$];
    logic [39:0] r;
    bit          par;
    if (c) q = '{1, 1, 1, 0, 0, 0};
    else   q = '{0, 0, 0, 1, 1, 1};
    for (int i = 15; i >= 0; i--) begin
      q.push_back(d[i]);
      q.push_back(!d[i]);
    end
    par = (($countones(d) % 2) == 0) ^ p;
    q.push_back(par);
    q.push_back(!par);
    for (int j = 0; j < 40; j++) r[39 - j] = q[j];
    return r;
  endfunction

  task automatic checkWord(input string name, input int base, input logic [15:0] d, input logic c,
                           input logic p, input logic exp_p, input bit expect_idle_after);
    logic [39:0] hbits;
    logic [39:0] lv;
    logic [1:0]  s;
    logic [15:0] dec_data;
    logic        dec_cd, dec_p, valid;
    int          wave_err, early;
    hbits    = modelHalfBits(d, c, p);
    wave_err = 0;
    early    = 0;
    for (int j = 0; j < WORD_CYC; j++) begin
      if (do_log[base + j] !== (hbits[39 - j / HB] ? 2'b10 : 2'b01) || busy_log[base + j] !== 1'b1)
        wave_err++;
      if (j > 0 && done_log[base + j] !== 1'b0) early++;
    end
    checkOutput({name, " wave"}, 32'(wave_err), 32'd0);
    checkOutput({name, " done early"}, 32'(early), 32'd0);
    checkOutput({name, " done pulse"}, 32'(done_log[base + WORD_CYC]), 32'd1);
    if (expect_idle_after)
      checkOutput({name, " idle after"},
                  32'({done_log[base + WORD_CYC + 1], busy_log[base + WORD_CYC], do_log[base + WORD_CYC]}), 32'd0);

    valid    = 1'b1;
    lv       = '0;
    dec_data = '0;
    dec_cd   = 1'b0;
    for (int h = 0; h < 40; h++) begin
      s = do_log[base + h * HB + HB / 2];
      if (s == 2'b10)      lv[39 - h] = 1'b1;
      else if (s == 2'b01) lv[39 - h] = 1'b0;
      else                 valid = 1'b0;
    end
    if (lv[39:34] == 6'b111000)      dec_cd = 1'b1;
    else if (lv[39:34] == 6'b000111) dec_cd = 1'b0;
    else                             valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (lv[33 - 2*i] == lv[32 - 2*i]) valid = 1'b0;
      dec_data[15 - i] = lv[33 - 2*i];
    end
    dec_p = lv[1];
    if (lv[1] == lv[0]) valid = 1'b0;
    checkOutput({name, " manchester valid"}, 32'(valid), 32'd1);
    checkOutput({name, " rx data"}, 32'(dec_data), 32'(d));
    checkOutput({name, " rx cd"}, 32'(dec_cd), 32'(c));
    checkOutput({name, " rx parity bit"}, 32'(dec_p), 32'(exp_p ^ p));
    checkOutput({name, " rx parity err"}, 32'(~^{dec_data, dec_p}), 32'(p));
  endtask

  task automatic applyStimulus(input vec_t v, input string name);
    writeWord(v.data, v.cd, v.pinv);
    record(WORD_CYC + 2);
    checkWord(name, 0, v.data, v.cd, v.pinv, v.exp_p, 1'b1);
  endtask

  initial begin
    vec_t v;
    int   cnt;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset oDO", 32'(dout), 32'd0);
    checkOutput("reset oBUSY", 32'(busy), 32'd0);
    checkOutput("reset oDONE", 32'(done), 32'd0);
    checkOutput("reset oREADY", 32'(ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle after reset", 32'({ready, busy, done, dout}), 32'b10000);

    vecs.push_back('{data: 16'h0000, cd: 1'b1, pinv: 1'b0, exp_p: 1'b1});
    vecs.push_back('{data: 16'h0001, cd: 1'b0, pinv: 1'b0, exp_p: 1'b0});
    vecs.push_back('{data: 16'hBEEF, cd: 1'b1, pinv: 1'b0, exp_p: 1'b0});
    vecs.push_back('{data: 16'hFFFF, cd: 1'b0, pinv: 1'b0, exp_p: 1'b1});
    vecs.push_back('{data: 16'hA5A5, cd: 1'b1, pinv: 1'b0, exp_p: 1'b1});
    vecs.push_back('{data: 16'h1234, cd: 1'b0, pinv: 1'b0, exp_p: 1'b0});
`ifdef MIL_TX_PARITY_INJECT_EN
    vecs.push_back('{data: 16'hBEEF, cd: 1'b1, pinv: 1'b1, exp_p: 1'b0});
`endif
    for (int i = 0; i < vecs.size(); i++)
      applyStimulus(vecs[i], $sformatf("vec%0d", i));

    for (int r = 0; r < 8; r++) begin
      v.data = 16'($urandom);
      v.cd   = 1'($urandom);
`ifdef MIL_TX_PARITY_INJECT_EN
      v.pinv = 1'($urandom_range(0, 1));
`else
      v.pinv = 1'b0;
`endif
      v.exp_p = (($countones(v.data) % 2) == 0);
      applyStimulus(v, $sformatf("rand%0d", r));
    end

    // Second word queued as soon as the first leaves the holding register.
    writeWord(16'hA5A5, 1'b1, 1'b0);
    fork
      record(2 * WORD_CYC + 2);
      writeWord(16'hFFFF, 1'b0, 1'b0);
    join
    checkWord("chainA", 0, 16'hA5A5, 1'b1, 1'b0, 1'b1, 1'b0);
    checkWord("chainB", WORD_CYC, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b1);
    cnt = 0;
    for (int j = 0; j < 2 * WORD_CYC; j++)
      if (do_log[j] == 2'b00 || busy_log[j] !== 1'b1) cnt++;
    checkOutput("chain gap", 32'(cnt), 32'd0);

    // A write against a full holding register must not overwrite it.
    writeWord(16'h0F0F, 1'b0, 1'b0);
    fork
      record(2 * WORD_CYC + 2);
      begin
        writeWord(16'h3C3C, 1'b1, 1'b0);
        data = 16'h1234;
        cd   = 1'b0;
        wr   = 1'b1;
        checkOutput("full ready low", 32'(ready), 32'd0);
        repeat (3) @(negedge clk);
        wr = 1'b0;
      end
    join
    checkWord("fullA", 0, 16'h0F0F, 1'b0, 1'b0, 1'b1, 1'b0);
    checkWord("fullB", WORD_CYC, 16'h3C3C, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("full ready after", 32'(ready), 32'd1);

    // Asynchronous reset during half-bit 20 kills the word.
    writeWord(16'h5555, 1'b1, 1'b0);
    record(165);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset oDO", 32'(dout), 32'd0);
    checkOutput("midreset oBUSY", 32'(busy), 32'd0);
    checkOutput("midreset oREADY", 32'(ready), 32'd1);
    checkOutput("midreset oDONE", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    record(WORD_CYC + 20);
    cnt = 0;
    for (int j = 0; j < WORD_CYC + 20; j++)
      if (done_log[j] !== 1'b0 || do_log[j] !== 2'b00 || busy_log[j] !== 1'b0) cnt++;
    checkOutput("midreset quiet", 32'(cnt), 32'd0);
    v = '{data: 16'hC3A1, cd: 1'b0, pinv: 1'b0, exp_p: 1'b0};
    applyStimulus(v, "postreset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mil_transmitter.md
# mil_transmitter

MIL-STD-1553B word transmitter: takes 16-bit words with a command/data flag, adds the sync pattern and odd parity, and drives a Manchester II bipolar pair to the bus transceiver. It is the transmit counterpart of the 1553 word receiver in the same SoC. Its output pair uses the same encoding the receiver samples: `[1]` is the positive leg and `[0]` is the negative leg. A one-word holding buffer lets the host queue the next word, so consecutive words of a message go out with no inter-word gap.

## Interface
Parameters:
- `CLK_PER_HALF_BIT`, default 8: iCLK cycles per Manchester half-bit. The default is 8, which gives 1 Mbit/s at 16 MHz. Legal range is 2..255.

Ports:
- `iCLK` in 1: the single clock; all logic is on the rising edge.
- `iRESET_N` in 1: asynchronous, active-low reset.
- `iDATA` in 16: word payload, MSB transmitted first.
- `iCD` in 1: sync type select. 1 selects command/status sync; 0 selects data sync.
- `iWR` in 1: write strobe. It is accepted on a rising edge only while `oREADY`=1.
- `oREADY` out 1: holding buffer is empty.
- `oDO` out 2: bus pair {pos,neg}.
  - 2'b10 = line high.
  - 2'b01 = line low.
  - 2'b00 = idle (transceiver inhibited).
  - 2'b11 is never driven.
- `oBUSY` out 1: a word is being shifted out.
- `oDONE` out 1: one-cycle pulse when a word's last half-bit completes.

## Operation
- Word frame = 40 half-bits, sent in this order:
  - 6 sync half-bits: 111000 when CD=1, 000111 when CD=0.
  - 32 data half-bits, D15 first. A data 1 is sent as 10 and a data 0 as 01.
  - 2 parity half-bits, using the same 1→10 / 0→01 encoding.
- Parity P = ~^iDATA, so the 17 bits {data,P} have odd parity.
- The frame is computed when the word moves from the holding register into a 40-bit half-bit shifter. Sync and parity are not computed on the fly.
- State machine (the holding register is independent):
  - IDLE:
    - `oDO`=00, `oBUSY`=0.
    - If the holding register is full, load the shifter, empty the holding register, and go to SEND.
  - SEND:
    - Each half-bit is held for `CLK_PER_HALF_BIT` cycles by a half-bit counter.
    - A 6-bit counter counts half-bits 0..39.
    - After half-bit 39 completes, pulse `oDONE`.
    - If the holding register is full, reload the shifter on that same edge and stay in SEND. This is the gapless chaining path.
    - Otherwise go to IDLE.
- Holding register:
  - It loads `iDATA`/`iCD` on an edge where `iWR`=1 and `oREADY`=1.
  - `oREADY` falls on that edge.
  - `oREADY` rises on the edge the shifter takes the word.
  - An `iWR` while `oREADY`=0 is ignored: no overwrite and no error flag.
- Simultaneous events: `iWR` arriving on the same edge the shifter drains the holding register is ignored, because `oREADY` was 0 when it was sampled. The host retries on the next cycle.
- Minimum inter-message gap is the host's responsibility; this block inserts no gap.

## Timing
- Reset values: `oDO`=2'b00, `oBUSY`=0, `oDONE`=0, `oREADY`=1. The holding register, shifter and counters all clear.
- Reset asserted mid-word:
  - `oDO` goes to 00 immediately (asynchronous).
  - The word is lost and no `oDONE` is generated.
- `oDO`, `oBUSY` and `oDONE` are registered outputs.
- Latency from an idle start:
  - `iWR` is accepted at edge k.
  - The shifter loads and `oBUSY` rises at edge k+1.
  - The first sync half-bit appears on `oDO` at edge k+1.
- Word duration is 40×`CLK_PER_HALF_BIT` cycles (320 at the default).
- `oDONE` is high for exactly the one cycle following the last parity half-bit.
- When words are chained, the next sync half-bit appears on the same edge that `oDONE` rises: `oDO` never passes through 00 and `oBUSY` stays high.
- `oDO` transitions only on half-bit boundaries.

## Configuration
- `MIL_TX_PARITY_INJECT_EN`
  - Defined:
    - Adds input port `iPARITY_INV` (1 bit), sampled together with `iDATA` on acceptance into the holding register.
    - When it is 1, that word is sent with P inverted, for fault-injection testing of remote terminals.
  - Undefined: the port does not exist and parity is always correct.

## Test plan
- **Command word:** reset, then `iWR` with iDATA=16'h0000, iCD=1.
  - `oDO`=10 for 24 cycles, then 01 for 24 cycles.
  - Then 16 repetitions of 01/10 (8 cycles each).
  - Then parity P=1 as 10/01.
  - `oDONE` pulses once at cycle 321 after acceptance; then `oDO`=00 and `oBUSY`=0.
- **Data sync and parity:** iDATA=16'h0001, iCD=0.
  - Sync is 01×24 cycles then 10×24 cycles.
  - Last data bit is 10/01.
  - Parity P=0 is sent as 01/10.
- **Gapless chaining:** write 16'hA5A5 (CD=1), then write 16'hFFFF (CD=0) as soon as `oREADY` rises.
  - `oBUSY` stays high for 640 cycles.
  - No 00 appears on `oDO` between the two words.
  - `oDONE` pulses at cycles 320 and 640 after the first word starts.
  - 16'hFFFF is sent with P=1.
- **Write while full:** with the holding register full, pulse `iWR` with 16'h1234.
  - The write is ignored.
  - The previously queued word is transmitted unchanged.
- **Reset mid-word:** assert `iRESET_N`=0 at half-bit 20.
  - `oDO`=00 at once; `oREADY`=1 and `oBUSY`=0.
  - No `oDONE`.
  - After release, the next write transmits normally.
- **Loopback and parity inject:**
  - Connect `oDO` to the receiver's bipolar input and send 16'hBEEF with iCD=1: the receiver reports data 16'hBEEF, CD=1, parity error 0.
  - With `MIL_TX_PARITY_INJECT_EN` defined and iPARITY_INV=1, the receiver reports parity error 1.
